// File: rtl/ch_state_controller_if.sv
// ---------------------------------------------------------------------------
// ch_state_pkg / ch_state_controller_if
//
// Purpose : shared state encoding for the channel sampling controller and
//           the trigger decoder, plus the command/status bundle between the
//           channel control logic and ch_state_controller.
//
// Interface signals (CNT_W = sample-window counter width):
//   start         control -> ctrl  begin a sampling window (INIT only)
//   stop          control -> ctrl  end a sampling window early
//   mode[2:0]     control -> ctrl  buffer select, captured on accepted start
//   sample_len    control -> ctrl  window length in cycles, 0 = until stop
//   readout_req   control -> ctrl  request readout (STOPPED only)
//   readout_done  control -> ctrl  readout finished (READOUT only)
//   rotate        control -> ctrl  fast-buffer rotation, only when the
//                                  CH_ROTATE_EN macro is defined
//   current_state ctrl -> control  registered state to the trigger decoder
//   busy          ctrl -> control  high whenever current_state != INIT
//   window_done   ctrl -> control  one-cycle pulse on entry to STOPPED
//   sample_count  ctrl -> control  cycles elapsed in the current window
//
// Modports: master = channel control logic, slave = ch_state_controller.
// ---------------------------------------------------------------------------
package ch_state_pkg;

  typedef enum logic [3:0] {
    STATE_INIT             = 4'd0,
    STATE_SAMPLING_A       = 4'd1,
    STATE_SAMPLING_B       = 4'd2,
    STATE_SAMPLING_C       = 4'd3,
    STATE_SAMPLING_D       = 4'd4,
    STATE_SAMPLING_E       = 4'd5,
    STATE_SAMPLING_A_AND_B = 4'd6,
    STATE_SAMPLING_C_AND_D = 4'd7,
    STATE_SAMPLING_ALL     = 4'd8,
    STATE_STOPPED          = 4'd9,
    STATE_READOUT          = 4'd10
  } state_t;

endpackage

interface ch_state_controller_if #(
  parameter int CNT_W = 16
);
  import ch_state_pkg::*;

  logic             start;
  logic             stop;
  logic [2:0]       mode;
  logic [CNT_W-1:0] sample_len;
  logic             readout_req;
  logic             readout_done;
`ifdef CH_ROTATE_EN
  logic             rotate;
`endif
  state_t           current_state;
  logic             busy;
  logic             window_done;
  logic [CNT_W-1:0] sample_count;

  modport master (
    output start, stop, mode, sample_len, readout_req, readout_done,
`ifdef CH_ROTATE_EN
    output rotate,
`endif
    input  current_state, busy, window_done, sample_count
  );

  modport slave (
    input  start, stop, mode, sample_len, readout_req, readout_done,
`ifdef CH_ROTATE_EN
    input  rotate,
`endif
    output current_state, busy, window_done, sample_count
  );

endinterface

// File: rtl/ch_state_controller.sv
// ---------------------------------------------------------------------------
// ch_state_controller
//
// Purpose : per-channel sampling state machine. Runs a programmable sampling
//           window on the selected buffer set, then sequences through
//           STOPPED and READOUT back to INIT. Its registered state feeds the
//           channel trigger decoder.
//
// Ports:
//   clk   channel clock, rising edge
//   rst   synchronous active-high reset
//   bus   ch_state_controller_if.slave (commands in, state/status out)
//
// Optional feature: define CH_ROTATE_EN to add the `rotate` input. With
// rotate captured high, a fast-buffer window (A..D) with non-zero length
// steps A->B->C->D on each expiry instead of stopping; expiry in D stops.
// ---------------------------------------------------------------------------
module ch_state_controller
  import ch_state_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  ch_state_controller_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] len_reg,   len_next;
  logic             busy_reg,  busy_next;
  logic             done_reg,  done_next;
  logic             sampling;
  logic             expired;
`ifdef CH_ROTATE_EN
  // The sampling state already encodes the active buffer; the captured mode
  // is only needed to decide whether rotation is allowed.
  logic [2:0]       mode_reg,   mode_next;
  logic             rotate_reg, rotate_next;
`endif

  function automatic state_t mode_to_state(input logic [2:0] m);
    case (m)
      3'd0:    return STATE_SAMPLING_A;
      3'd1:    return STATE_SAMPLING_B;
      3'd2:    return STATE_SAMPLING_C;
      3'd3:    return STATE_SAMPLING_D;
      3'd4:    return STATE_SAMPLING_E;
      3'd5:    return STATE_SAMPLING_A_AND_B;
      3'd6:    return STATE_SAMPLING_C_AND_D;
      default: return STATE_SAMPLING_ALL;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_next   = len_reg;
    sampling   = 1'b0;
    expired    = 1'b0;
`ifdef CH_ROTATE_EN
    mode_next   = mode_reg;
    rotate_next = rotate_reg;
`endif
    case (state_reg)
      STATE_INIT: begin
        if (bus.start) begin
          state_next = mode_to_state(bus.mode);
          len_next   = bus.sample_len;
          count_next = '0;
`ifdef CH_ROTATE_EN
          mode_next   = bus.mode;
          rotate_next = bus.rotate;
`endif
        end
      end
      STATE_SAMPLING_A, STATE_SAMPLING_B, STATE_SAMPLING_C,
      STATE_SAMPLING_D, STATE_SAMPLING_E, STATE_SAMPLING_A_AND_B,
      STATE_SAMPLING_C_AND_D, STATE_SAMPLING_ALL: begin
        sampling = 1'b1;
        expired  = (len_reg != '0) && (count_reg == len_reg - CNT_W'(1));
        if (bus.stop) begin
          state_next = STATE_STOPPED;
        end else if (expired) begin
          state_next = STATE_STOPPED;
`ifdef CH_ROTATE_EN
          // Rotation only ever starts from a fast buffer, so the state
          // here is one of A..D; D has no successor and stops.
          if (rotate_reg && (mode_reg <= 3'd3)) begin
            case (state_reg)
              STATE_SAMPLING_A: begin state_next = STATE_SAMPLING_B; count_next = '0; end
              STATE_SAMPLING_B: begin state_next = STATE_SAMPLING_C; count_next = '0; end
              STATE_SAMPLING_C: begin state_next = STATE_SAMPLING_D; count_next = '0; end
              default:          state_next = STATE_STOPPED;
            endcase
          end
`endif
        end else if (count_reg != '1) begin
          // Saturates only in free-running (L=0) windows; a bounded window
          // always expires before reaching all-ones.
          count_next = count_reg + CNT_W'(1);
        end
      end
      STATE_STOPPED: begin
        if (bus.readout_req) state_next = STATE_READOUT;
      end
      STATE_READOUT: begin
        if (bus.readout_done) begin
          state_next = STATE_INIT;
          count_next = '0;
        end
      end
      default: begin
        state_next = STATE_INIT;
        count_next = '0;
      end
    endcase
    busy_next = (state_next != STATE_INIT);
    done_next = sampling && (state_next == STATE_STOPPED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= STATE_INIT;
      count_reg <= '0;
      len_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef CH_ROTATE_EN
      mode_reg   <= '0;
      rotate_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef CH_ROTATE_EN
      mode_reg   <= mode_next;
      rotate_reg <= rotate_next;
`endif
    end
  end

  assign bus.current_state = state_reg;
  assign bus.busy          = busy_reg;
  assign bus.window_done   = done_reg;
  assign bus.sample_count  = count_reg;

endmodule

// File: tb/tb_ch_state_controller.sv
// ---------------------------------------------------------------------------
// tb_ch_state_controller
//
// Directed bench for ch_state_controller: reset values, bounded and
// free-running windows, early stop, stop at window expiry, ignored inputs,
// reset mid-window and mid-readout, and fast-buffer rotation when
// CH_ROTATE_EN is defined.
// ---------------------------------------------------------------------------
module tb_ch_state_controller;
  import ch_state_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ch_state_controller_if #(.CNT_W(CNT_W)) bus ();

  ch_state_controller #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input state_t st, input logic busy,
                           input logic done, input logic [CNT_W-1:0] cnt);
    check({tag, ".state"}, 32'(bus.current_state), 32'(st));
    check({tag, ".busy"},  32'(bus.busy),          32'(busy));
    check({tag, ".done"},  32'(bus.window_done),   32'(done));
    check({tag, ".count"}, 32'(bus.sample_count),  32'(cnt));
  endtask

  task automatic do_start(input logic [2:0] m, input logic [CNT_W-1:0] len);
    bus.start = 1'b1; bus.mode = m; bus.sample_len = len;
    tick();
    bus.start = 1'b0;
  endtask

  // From STOPPED: readout_req, then readout_done, back to INIT.
  task automatic do_readout(input string tag, input logic [CNT_W-1:0] held);
    bus.readout_req = 1'b1;
    tick();
    bus.readout_req = 1'b0;
    check_out({tag, ".readout"}, STATE_READOUT, 1'b1, 1'b0, held);
    bus.readout_done = 1'b1;
    tick();
    bus.readout_done = 1'b0;
    check_out({tag, ".init"}, STATE_INIT, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = '0; bus.sample_len = '0;
    bus.readout_req = 1'b0; bus.readout_done = 1'b0;
`ifdef CH_ROTATE_EN
    bus.rotate = 1'b0;
`endif

    // Reset values
    tick(); tick();
    check_out("reset", STATE_INIT, 1'b0, 1'b0, '0);
    rst = 1'b0;
    tick();
    check_out("idle", STATE_INIT, 1'b0, 1'b0, '0);

    // Bounded window: A_AND_B, L=4
    do_start(3'd5, 16'd4);
    check_out("ab.c0", STATE_SAMPLING_A_AND_B, 1'b1, 1'b0, 16'd0);
    bus.mode = 3'd0; bus.sample_len = 16'd9;   // no effect after capture
    for (int i = 1; i < 4; i++) begin
      tick();
      check_out($sformatf("ab.c%0d", i), STATE_SAMPLING_A_AND_B, 1'b1, 1'b0, i[CNT_W-1:0]);
    end
    tick();
    check_out("ab.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd3);
    bus.start = 1'b1;                           // ignored in STOPPED
    tick();
    bus.start = 1'b0;
    check_out("ab.start_ign", STATE_STOPPED, 1'b1, 1'b0, 16'd3);
    bus.readout_done = 1'b1;                    // ignored in STOPPED
    tick();
    bus.readout_done = 1'b0;
    check_out("ab.done_ign", STATE_STOPPED, 1'b1, 1'b0, 16'd3);
    do_readout("ab", 16'd3);

    // Free-running ALL window, stop after 100 cycles
    do_start(3'd7, 16'd0);
    check_out("all.c0", STATE_SAMPLING_ALL, 1'b1, 1'b0, 16'd0);
    repeat (100) tick();
    check_out("all.c100", STATE_SAMPLING_ALL, 1'b1, 1'b0, 16'd100);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_out("all.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd100);
    do_readout("all", 16'd100);

    // Stop coinciding with expiry, C with L=3
    do_start(3'd2, 16'd3);
    tick();
    tick();
    check_out("cx.c2", STATE_SAMPLING_C, 1'b1, 1'b0, 16'd2);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_out("cx.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd2);
    tick();
    check_out("cx.single", STATE_STOPPED, 1'b1, 1'b0, 16'd2);
    do_readout("cx", 16'd2);

    // Reset mid-SAMPLING_E
    do_start(3'd4, 16'd0);
    repeat (5) tick();
    check_out("e.c5", STATE_SAMPLING_E, 1'b1, 1'b0, 16'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("e.rst", STATE_INIT, 1'b0, 1'b0, '0);

    // Reset mid-READOUT
    do_start(3'd4, 16'd2);
    tick();
    tick();
    check_out("e2.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd1);
    bus.readout_req = 1'b1;
    tick();
    bus.readout_req = 1'b0;
    check_out("e2.readout", STATE_READOUT, 1'b1, 1'b0, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("e2.rst", STATE_INIT, 1'b0, 1'b0, '0);
    do_start(3'd4, 16'd0);
    check_out("e3.start", STATE_SAMPLING_E, 1'b1, 1'b0, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Single fast buffer, no rotation: A, A, STOPPED
    do_start(3'd0, 16'd2);
    check_out("a.c0", STATE_SAMPLING_A, 1'b1, 1'b0, 16'd0);
    tick();
    check_out("a.c1", STATE_SAMPLING_A, 1'b1, 1'b0, 16'd1);
    tick();
    check_out("a.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd1);
    do_readout("a", 16'd1);

`ifdef CH_ROTATE_EN
    begin
      state_t seq [4];
      seq[0] = STATE_SAMPLING_A; seq[1] = STATE_SAMPLING_B;
      seq[2] = STATE_SAMPLING_C; seq[3] = STATE_SAMPLING_D;

      // Full rotation A,A,B,B,C,C,D,D then STOPPED
      bus.rotate = 1'b1;
      do_start(3'd0, 16'd2);
      bus.rotate = 1'b0;
      for (int b = 0; b < 4; b++) begin
        check_out($sformatf("rot.%0d.c0", b), seq[b], 1'b1, 1'b0, 16'd0);
        tick();
        check_out($sformatf("rot.%0d.c1", b), seq[b], 1'b1, 1'b0, 16'd1);
        tick();
      end
      check_out("rot.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd1);
      tick();
      check_out("rot.single", STATE_STOPPED, 1'b1, 1'b0, 16'd1);
      do_readout("rot", 16'd1);

      // Rotation interrupted by stop during B
      bus.rotate = 1'b1;
      do_start(3'd0, 16'd2);
      bus.rotate = 1'b0;
      tick();
      tick();
      check_out("rs.b0", STATE_SAMPLING_B, 1'b1, 1'b0, 16'd0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check_out("rs.stopped", STATE_STOPPED, 1'b1, 1'b1, 16'd0);
      do_readout("rs", 16'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ch_state_controller.md
# ch_state_controller

Per-channel sampling state machine that generates the `state_t` value consumed by the channel trigger decoder. It accepts start/stop/readout commands from the channel control logic, runs a programmable sampling window on the selected buffer set (A–D fast, E slow, or combinations), and sequences through STOPPED and READOUT back to INIT. It sits directly upstream of the trigger decoder, which turns its state into active-low buffer triggers.

## Interface
- `CNT_W`, 16: width of the sample-window length and counter.

- `clk` in 1: channel clock; all logic on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: single-cycle pulse; begins a sampling window when in STATE_INIT.
- `stop` in 1: single-cycle pulse; ends any sampling window early.
- `mode` in 3: buffer select, captured on accepted `start`:
  - 0 A, 1 B, 2 C, 3 D, 4 E
  - 5 A_AND_B, 6 C_AND_D, 7 ALL
- `sample_len` in CNT_W: window length in cycles, captured on accepted `start`; 0 = run until `stop`.
- `readout_req` in 1: request readout; honoured only in STATE_STOPPED.
- `readout_done` in 1: readout finished; honoured only in STATE_READOUT.
- `current_state` out state_t: registered state to the trigger decoder.
- `busy` out 1: registered; high whenever `current_state` ≠ STATE_INIT.
- `window_done` out 1: one-cycle pulse on the cycle `current_state` first shows STATE_STOPPED.
- `sample_count` out CNT_W: cycles elapsed in the current sampling window.

## Operation
- States: INIT, SAMPLING_{A,B,C,D,E,A_AND_B,C_AND_D,ALL}, STOPPED, READOUT.
- INIT with `start`=1:
  - Go to the SAMPLING state selected by `mode`.
  - Latch `mode` and `sample_len`.
  - Clear `sample_count`.
- SAMPLING (any), checked in priority order:
  1. `stop`=1: go to STOPPED.
  2. Latched length L≠0 and `sample_count`==L−1: go to STOPPED. Rotation exception: see Configuration.
  3. Otherwise stay; `sample_count` increments.
- `sample_count` saturates at all-ones when L=0. It holds its value in STOPPED and READOUT, and clears on entry to INIT.
- STOPPED: `readout_req`=1 → READOUT. `start` and `stop` are ignored.
- READOUT: `readout_done`=1 → INIT. All other inputs are ignored.
- `start` outside INIT is ignored. `stop` outside SAMPLING is ignored.
- `mode` and `sample_len` changes after capture have no effect until the next accepted `start`.
- `rst`=1 at any time, including mid-window or mid-readout:
  - `current_state` = STATE_INIT.
  - `sample_count` = 0, `busy` = 0, `window_done` = 0.
  - Latched mode and length are cleared.

## Timing
- All outputs are registered.
- Reset values: `current_state` STATE_INIT, `busy` 0, `window_done` 0, `sample_count` 0.
- `start` accepted at edge n → SAMPLING visible after edge n. Exactly L cycles in SAMPLING, then STOPPED.
- `stop` sampled at edge k → STOPPED after edge k.
- `stop` coinciding with window expiry → STOPPED; `window_done` pulses once.
- `readout_req` / `readout_done` → one-cycle transition latency each.
- `busy` changes on the same edge as `current_state`.

## Configuration
- Macro `CH_ROTATE_EN`.
- **Defined:**
  - Adds input `rotate` (1 bit), captured on accepted `start`.
  - Applies when captured `rotate`=1 and captured `mode`∈0..3 and L≠0.
  - Window expiry in A/B/C advances to the next fast buffer (A→B→C→D) and clears `sample_count`, instead of going to STOPPED.
  - Expiry in D goes to STOPPED.
  - `stop` still has priority and goes straight to STOPPED.
  - `window_done` pulses only on entry to STOPPED.
- **Undefined:**
  - No `rotate` port.
  - Every window ends in STOPPED after one buffer set.

## Test plan
- Reset, then `start`, `mode`=5, `sample_len`=4 → SAMPLING_A_AND_B for exactly 4 cycles, `sample_count` 0..3. Then STOPPED with `window_done` high for 1 cycle and `busy`=1.
- `mode`=7, `sample_len`=0; `stop` after 100 cycles → STOPPED the next cycle with `sample_count`=100. Then `readout_req` → READOUT, then `readout_done` → INIT with `busy`=0 and `sample_count`=0.
- Boundary and ignored inputs:
  - `stop` coinciding with the last window cycle (L=3) → single STOPPED entry, single `window_done` pulse.
  - `start` in STOPPED is ignored.
  - `readout_done` in STOPPED is ignored.
- `rst` asserted mid-SAMPLING_E and again mid-READOUT → next cycle STATE_INIT, all outputs at reset values. A following `start` with `mode`=4 → SAMPLING_E.
- `CH_ROTATE_EN` defined, `rotate`=1, `mode`=0, L=2 → A,A,B,B,C,C,D,D, then STOPPED with one `window_done`.
- Same rotation setup with `stop` during B → STOPPED immediately.
- `mode`=0 with macro undefined, L=2 → A,A, then STOPPED.
